// File: rtl/painterengine_gpu_dma_writer_mc.sv
// Multi-channel AXI4 write DMA: moves one job from a selected producer stream
// into memory as INCR bursts bounded by PARAM_MAX_BURST and 4 KB pages.
module painterengine_gpu_dma_writer_mc #(
  parameter int unsigned PARAM_CHANNELS      = 4,
  parameter int unsigned PARAM_DATA_WIDTH    = 32,
  parameter int unsigned PARAM_MAX_BURST     = 16,
  parameter int unsigned PARAM_TIMEOUT_WIDTH = 16
) (
  input  logic                                      i_wire_clock,
  input  logic                                      i_wire_resetn,
  input  logic                                      i_wire_start,
  input  logic [PARAM_CHANNELS-1:0]                 i_wire_router,
  input  logic [32*PARAM_CHANNELS-1:0]              i_wire_address,
  input  logic [32*PARAM_CHANNELS-1:0]              i_wire_length,
  input  logic [PARAM_DATA_WIDTH*PARAM_CHANNELS-1:0] i_wire_data,
  input  logic [PARAM_CHANNELS-1:0]                 i_wire_data_valid,
  output logic [PARAM_CHANNELS-1:0]                 o_wire_data_next,
  output logic                                      o_wire_busy,
  output logic                                      o_wire_done,
  output logic                                      o_wire_error,
  output logic [2:0]                                o_wire_error_type,
  output logic [0:0]                                o_wire_M_AXI_AWID,
  output logic [31:0]                               o_wire_M_AXI_AWADDR,
  output logic [7:0]                                o_wire_M_AXI_AWLEN,
  output logic [2:0]                                o_wire_M_AXI_AWSIZE,
  output logic [1:0]                                o_wire_M_AXI_AWBURST,
  output logic                                      o_wire_M_AXI_AWLOCK,
  output logic [3:0]                                o_wire_M_AXI_AWCACHE,
  output logic [2:0]                                o_wire_M_AXI_AWPROT,
  output logic [3:0]                                o_wire_M_AXI_AWQOS,
  output logic                                      o_wire_M_AXI_AWVALID,
  input  logic                                      i_wire_M_AXI_AWREADY,
  output logic [PARAM_DATA_WIDTH-1:0]               o_wire_M_AXI_WDATA,
  output logic [PARAM_DATA_WIDTH/8-1:0]             o_wire_M_AXI_WSTRB,
  output logic                                      o_wire_M_AXI_WLAST,
  output logic                                      o_wire_M_AXI_WVALID,
  input  logic                                      i_wire_M_AXI_WREADY,
  input  logic [0:0]                                i_wire_M_AXI_BID,
  input  logic [1:0]                                i_wire_M_AXI_BRESP,
  input  logic                                      i_wire_M_AXI_BVALID,
  output logic                                      o_wire_M_AXI_BREADY
);

  localparam int unsigned BYTES     = PARAM_DATA_WIDTH / 8;
  localparam int unsigned SIZE_LOG2 = $clog2(BYTES);
  localparam int unsigned CH_W      = (PARAM_CHANNELS > 1) ? $clog2(PARAM_CHANNELS) : 1;
  localparam int unsigned BEAT_W    = 9;
  localparam int unsigned TO_W      = PARAM_TIMEOUT_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CALC, S_AW, S_W, S_B, S_DONE, S_ERROR
  } state_e;

  state_e                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [PARAM_CHANNELS-1:0] router_q, router_d;
  logic [31:0]               base_q, base_d, length_q, length_d;
  logic [31:0]               offset_q, offset_d, cur_addr_q, cur_addr_d;
  logic [BEAT_W-1:0]         burst_q, burst_d, beat_q, beat_d;
  logic [TO_W-1:0]           to_q, to_d;
  logic [2:0]                err_q, err_d;

  logic [CH_W-1:0]             start_ch_c;
  logic [31:0]                 start_addr_c, start_len_c;
  logic [PARAM_DATA_WIDTH-1:0] sel_data_c;
  logic                        sel_valid_c;
  logic [31:0]                 calc_addr_c, to4k_c, burst_c;
  logic                        aw_hs_c, w_hs_c, b_hs_c, last_beat_c;

  // Lowest set router bit picks the slice latched at start; the selected
  // stream is muxed from the latched channel index.
  always_comb begin
    start_ch_c   = '0;
    start_addr_c = '0;
    start_len_c  = '0;
    for (int i = PARAM_CHANNELS - 1; i >= 0; i--) begin
      if (i_wire_router[i]) begin
        start_ch_c   = CH_W'(i);
        start_addr_c = i_wire_address[i*32 +: 32];
        start_len_c  = i_wire_length[i*32 +: 32];
      end
    end
    sel_data_c  = '0;
    sel_valid_c = 1'b0;
    for (int i = 0; i < PARAM_CHANNELS; i++) begin
      if (CH_W'(i) == ch_q) begin
        sel_data_c  = i_wire_data[i*PARAM_DATA_WIDTH +: PARAM_DATA_WIDTH];
        sel_valid_c = i_wire_data_valid[i];
      end
    end
  end

  // Burst size: smallest of remaining beats, max burst and beats left in the 4 KB page.
  always_comb begin
    calc_addr_c = base_q + (offset_q << SIZE_LOG2);
    to4k_c      = (32'd4096 - {20'd0, calc_addr_c[11:0]}) >> SIZE_LOG2;
    burst_c     = length_q - offset_q;
    if (burst_c > 32'(PARAM_MAX_BURST)) burst_c = 32'(PARAM_MAX_BURST);
    if (burst_c > to4k_c)               burst_c = to4k_c;
  end

  assign aw_hs_c     = (state_q == S_AW) && i_wire_M_AXI_AWREADY;
  assign w_hs_c      = (state_q == S_W) && sel_valid_c && i_wire_M_AXI_WREADY;
  assign b_hs_c      = (state_q == S_B) && i_wire_M_AXI_BVALID;
  assign last_beat_c = (beat_q == burst_q - BEAT_W'(1));

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      router_q   <= '0;
      base_q     <= '0;
      length_q   <= '0;
      offset_q   <= '0;
      cur_addr_q <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      to_q       <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      router_q   <= router_d;
      base_q     <= base_d;
      length_q   <= length_d;
      offset_q   <= offset_d;
      cur_addr_q <= cur_addr_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      to_q       <= to_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    router_d   = router_q;
    base_d     = base_q;
    length_d   = length_q;
    offset_d   = offset_q;
    cur_addr_d = cur_addr_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    err_d      = err_q;
    to_d       = to_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_wire_start) begin
          ch_d     = start_ch_c;
          router_d = i_wire_router;
          base_d   = start_addr_c;
          length_d = start_len_c;
          offset_d = '0;
          err_d    = 3'd0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!$onehot(router_q)) begin
          err_d   = 3'd1;
          state_d = S_ERROR;
        end else if ((base_q[SIZE_LOG2-1:0] != '0) || (length_q == 32'd0)) begin
          err_d   = 3'd2;
          state_d = S_ERROR;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        cur_addr_d = calc_addr_c;
        burst_d    = BEAT_W'(burst_c);
        state_d    = S_AW;
      end
      S_AW: begin
        if (aw_hs_c) begin
          beat_d  = '0;
          state_d = S_W;
        end else if (to_q == '1) begin
          err_d   = 3'd5;
          state_d = S_ERROR;
        end
      end
      S_W: begin
        if (w_hs_c) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat_c) begin
            offset_d = offset_q + 32'(burst_q);
            state_d  = S_B;
          end
        end else if (to_q == '1) begin
          err_d   = 3'd4;
          state_d = S_ERROR;
        end
      end
      S_B: begin
        if (b_hs_c) begin
          if (i_wire_M_AXI_BRESP[1]) begin
            err_d   = 3'd3;
            state_d = S_ERROR;
          end else if (offset_q >= length_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end else if (to_q == '1) begin
          err_d   = 3'd4;
          state_d = S_ERROR;
        end
      end
      default: ;
    endcase
    // Stall counter only runs while waiting on a handshake in one phase.
    if ((state_d != state_q) || aw_hs_c || w_hs_c || b_hs_c) begin
      to_d = '0;
    end else if ((state_q == S_AW) || (state_q == S_W) || (state_q == S_B)) begin
      to_d = to_q + TO_W'(1);
    end
  end

  always_comb begin
    o_wire_data_next = '0;
    for (int i = 0; i < PARAM_CHANNELS; i++) begin
      o_wire_data_next[i] = w_hs_c && (CH_W'(i) == ch_q);
    end
  end

  assign o_wire_busy       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  assign o_wire_done       = (state_q == S_DONE);
  assign o_wire_error      = (state_q == S_ERROR);
  assign o_wire_error_type = err_q;

  assign o_wire_M_AXI_AWID    = 1'b0;
  assign o_wire_M_AXI_AWADDR  = (state_q == S_AW) ? cur_addr_q : 32'd0;
  assign o_wire_M_AXI_AWLEN   = (state_q == S_AW) ? 8'(burst_q - BEAT_W'(1)) : 8'd0;
  assign o_wire_M_AXI_AWSIZE  = 3'(SIZE_LOG2);
  assign o_wire_M_AXI_AWBURST = 2'b01;
  assign o_wire_M_AXI_AWLOCK  = 1'b0;
  assign o_wire_M_AXI_AWCACHE = 4'b0010;
  assign o_wire_M_AXI_AWPROT  = 3'b000;
  assign o_wire_M_AXI_AWQOS   = 4'b0000;
  assign o_wire_M_AXI_AWVALID = (state_q == S_AW);

  assign o_wire_M_AXI_WDATA  = (state_q == S_W) ? sel_data_c : '0;
  assign o_wire_M_AXI_WSTRB  = '1;
  assign o_wire_M_AXI_WLAST  = (state_q == S_W) && last_beat_c;
  assign o_wire_M_AXI_WVALID = (state_q == S_W) && sel_valid_c;
  assign o_wire_M_AXI_BREADY = (state_q == S_B);

  logic unused_c;
  assign unused_c = ^{i_wire_M_AXI_BID, i_wire_M_AXI_BRESP[0], burst_c[31:BEAT_W]};

endmodule

// File: tb/tb_painterengine_gpu_dma_writer_mc.sv
// Bench for painterengine_gpu_dma_writer_mc: directed job table, hand-written
// reset/restart sequence and random jobs against a burst-splitting reference.
module tb_painterengine_gpu_dma_writer_mc;
  localparam int unsigned CH = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 16;
  localparam int unsigned TW = 8;
  localparam int unsigned BY = DW / 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [CH-1:0]     router;
  logic [32*CH-1:0]  address, length;
  logic [DW*CH-1:0]  data;
  logic [CH-1:0]     dv;
  logic [CH-1:0]     data_next;
  logic              busy, done, error;
  logic [2:0]        etype;
  logic [0:0]        awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize, awprot;
  logic [1:0]        awburst;
  logic              awlock, awvalid, awready;
  logic [3:0]        awcache, awqos;
  logic [DW-1:0]     wdata;
  logic [BY-1:0]     wstrb;
  logic              wlast, wvalid, wready;
  logic [0:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid, bready;

  always #5 clk = ~clk;

  painterengine_gpu_dma_writer_mc #(
    .PARAM_CHANNELS(CH), .PARAM_DATA_WIDTH(DW),
    .PARAM_MAX_BURST(MB), .PARAM_TIMEOUT_WIDTH(TW)
  ) dut (
    .i_wire_clock(clk), .i_wire_resetn(rstn), .i_wire_start(start),
    .i_wire_router(router), .i_wire_address(address), .i_wire_length(length),
    .i_wire_data(data), .i_wire_data_valid(dv), .o_wire_data_next(data_next),
    .o_wire_busy(busy), .o_wire_done(done), .o_wire_error(error),
    .o_wire_error_type(etype),
    .o_wire_M_AXI_AWID(awid), .o_wire_M_AXI_AWADDR(awaddr), .o_wire_M_AXI_AWLEN(awlen),
    .o_wire_M_AXI_AWSIZE(awsize), .o_wire_M_AXI_AWBURST(awburst),
    .o_wire_M_AXI_AWLOCK(awlock), .o_wire_M_AXI_AWCACHE(awcache),
    .o_wire_M_AXI_AWPROT(awprot), .o_wire_M_AXI_AWQOS(awqos),
    .o_wire_M_AXI_AWVALID(awvalid), .i_wire_M_AXI_AWREADY(awready),
    .o_wire_M_AXI_WDATA(wdata), .o_wire_M_AXI_WSTRB(wstrb), .o_wire_M_AXI_WLAST(wlast),
    .o_wire_M_AXI_WVALID(wvalid), .i_wire_M_AXI_WREADY(wready),
    .i_wire_M_AXI_BID(bid), .i_wire_M_AXI_BRESP(bresp), .i_wire_M_AXI_BVALID(bvalid),
    .o_wire_M_AXI_BREADY(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Slave/producer behaviour knobs
  int unsigned pct_rdy = 100, pct_v = 100;
  logic [1:0]  bresp_cfg = 2'b00;
  bit          noise = 1'b0;

  int unsigned idx [CH];
  int unsigned aw_addr_log[$], aw_len_log[$];
  int unsigned exp_addr[$], exp_len[$];
  int          cyc = 0, start_cyc = 0, first_aw_cyc = -1, last_b_cyc = -1;
  int unsigned beats_job = 0, beat_in_burst = 0, cur_len = 0;
  int          cur_ch = 0;
  bit          prev_awvalid = 1'b0, last_aw = 1'b0;
  logic [31:0] prev_awaddr;
  bit          s_busy, s_done, s_error;
  logic [2:0]  s_etype;

  function automatic logic [DW-1:0] pat(input int c, input int unsigned k);
    return {c[7:0], k[23:0]};
  endfunction

  // Reference: walk the job splitting at remaining length, max burst and 4 KB pages.
  function automatic void model(input int unsigned base, input int unsigned len);
    int unsigned off, a, room, b;
    exp_addr.delete();
    exp_len.delete();
    off = 0;
    while (off < len) begin
      a    = base + off * BY;
      room = (4096 - (a % 4096)) / BY;
      b    = len - off;
      if (b > MB)   b = MB;
      if (b > room) b = room;
      exp_addr.push_back(a);
      exp_len.push_back(b);
      off += b;
    end
  endfunction

  // One clock: drive inputs just after posedge, sample/score on negedge.
  task automatic cycle(input bit do_start);
    logic [CH-1:0] exp_next;
    start = do_start;
    if (!do_start && noise) begin
      router  = CH'($urandom);
      address = {$urandom, $urandom, $urandom, $urandom};
      length  = {$urandom, $urandom, $urandom, $urandom};
      start   = last_aw && ($urandom % 2 == 0);
    end
    for (int c = 0; c < CH; c++) begin
      dv[c] = ($urandom % 100) < pct_v;
      data[c*DW +: DW] = pat(c, idx[c]);
    end
    awready = ($urandom % 100) < pct_rdy;
    wready  = ($urandom % 100) < pct_rdy;
    bvalid  = ($urandom % 100) < pct_rdy;
    bresp   = bresp_cfg;
    @(negedge clk);
    if (awvalid && prev_awvalid) chk("awaddr_stable", awaddr, prev_awaddr);
    if (awvalid && !prev_awvalid) begin
      if (first_aw_cyc < 0) begin
        first_aw_cyc = cyc;
        chk("start_to_aw_cycles", cyc - start_cyc, 3);
      end else begin
        chk("b_to_aw_cycles", cyc - last_b_cyc, 2);
      end
    end
    if (awvalid && awready) begin
      aw_addr_log.push_back(awaddr);
      aw_len_log.push_back(awlen);
      cur_len = awlen;
      beat_in_burst = 0;
    end
    exp_next = '0;
    if (wvalid) chk("wvalid_from_selected", dv[cur_ch], 1);
    if (wvalid && wready) begin
      exp_next[cur_ch] = 1'b1;
      chk("wdata", wdata, pat(cur_ch, idx[cur_ch]));
      chk("wlast", wlast, beat_in_burst == cur_len);
      beat_in_burst++;
      beats_job++;
    end
    chk("data_next", data_next, exp_next);
    for (int c = 0; c < CH; c++) if (data_next[c]) idx[c]++;
    if (bready && bvalid) begin
      last_b_cyc = cyc;
      chk("beats_per_burst", beat_in_burst, cur_len + 1);
    end
    s_busy = busy; s_done = done; s_error = error; s_etype = etype;
    prev_awvalid = awvalid;
    prev_awaddr  = awaddr;
    last_aw      = awvalid;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [CH-1:0] rtr, input int unsigned base, input int unsigned len,
                         input logic [2:0] exp_err, input int exp_aw, input string tag);
    int c, n;
    c = 0;
    for (int i = CH - 1; i >= 0; i--) if (rtr[i]) c = i;
    router  = rtr;
    address = {$urandom, $urandom, $urandom, $urandom};
    length  = {$urandom, $urandom, $urandom, $urandom};
    address[c*32 +: 32] = base;
    length[c*32 +: 32]  = len;
    aw_addr_log.delete();
    aw_len_log.delete();
    cur_ch = c; beats_job = 0; first_aw_cyc = -1; last_b_cyc = -1;
    start_cyc = cyc;
    cycle(1'b1);
    n = 0;
    do begin
      cycle(1'b0);
      n++;
    end while (s_busy && n < 20000);
    chk({tag, "_finished"}, n < 20000, 1);
    chk({tag, "_done"}, s_done, exp_err == 0);
    chk({tag, "_error"}, s_error, exp_err != 0);
    chk({tag, "_error_type"}, s_etype, exp_err);
    if (exp_err == 0) begin
      model(base, len);
      chk({tag, "_burst_count"}, aw_addr_log.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < aw_addr_log.size(); i++) begin
        chk($sformatf("%s_awaddr%0d", tag, i), aw_addr_log[i], exp_addr[i]);
        chk($sformatf("%s_awlen%0d", tag, i), aw_len_log[i], exp_len[i] - 1);
      end
      chk({tag, "_beats"}, beats_job, len);
    end else begin
      chk({tag, "_aw_count"}, aw_addr_log.size(), exp_aw);
    end
  endtask

  typedef struct {
    logic [CH-1:0] rtr;
    int unsigned   base;
    int unsigned   len;
    int unsigned   rdy;
    int unsigned   v;
    logic [1:0]    resp;
    logic [2:0]    err;
    int            aw;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int aw_cycles;
    rstn = 1'b0; start = 1'b0; router = '0; address = '0; length = '0;
    data = '0; dv = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    bresp = 2'b00; bid = 1'b0;
    for (int c = 0; c < CH; c++) idx[c] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_etype", etype, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid_wlast_bready", {wvalid, wlast, bready}, 0);
    chk("rst_data_next", data_next, 0);
    chk("awcache_const", {awsize, awburst, awcache, wstrb}, {3'd2, 2'b01, 4'b0010, 4'hf});
    rstn = 1'b1;

    //             rtr      base       len rdy  v   resp   err aw
    vecs.push_back('{4'b0001, 32'h1000,  10, 100, 100, 2'b00, 0, 0});
    vecs.push_back('{4'b0100, 32'h0FF8,  40, 100, 100, 2'b00, 0, 0});
    vecs.push_back('{4'b0010, 32'h3000,   5,  50,  50, 2'b00, 0, 0});
    vecs.push_back('{4'b0110, 32'h1000,   4, 100, 100, 2'b00, 1, 0});
    vecs.push_back('{4'b0001, 32'h1000,   4, 100, 100, 2'b00, 0, 0});
    vecs.push_back('{4'b0010, 32'h1002,   4, 100, 100, 2'b00, 2, 0});
    vecs.push_back('{4'b0010, 32'h1004,   4, 100, 100, 2'b00, 0, 0});
    vecs.push_back('{4'b1000, 32'h2000,   0, 100, 100, 2'b00, 2, 0});
    vecs.push_back('{4'b1000, 32'h2000,   3, 100, 100, 2'b00, 0, 0});
    vecs.push_back('{4'b0000, 32'h0000,   1, 100, 100, 2'b00, 1, 0});
    vecs.push_back('{4'b0001, 32'h0FC0,  40,  80,  80, 2'b00, 0, 0});
    vecs.push_back('{4'b0001, 32'h0100,   8, 100, 100, 2'b10, 3, 1});
    vecs.push_back('{4'b0100, 32'h0100,   8, 100, 100, 2'b11, 3, 1});
    vecs.push_back('{4'b0100, 32'h7FC0,  20,  70,  90, 2'b01, 0, 0});
    vecs.push_back('{4'b0010, 32'h4000,   4,   0, 100, 2'b00, 5, 0});
    vecs.push_back('{4'b1000, 32'h4000,   4, 100,   0, 2'b00, 4, 1});
    vecs.push_back('{4'b1000, 32'h4010,   6, 100, 100, 2'b00, 0, 0});

    foreach (vecs[i]) begin
      pct_rdy = vecs[i].rdy; pct_v = vecs[i].v; bresp_cfg = vecs[i].resp;
      run_job(vecs[i].rtr, vecs[i].base, vecs[i].len, vecs[i].err, vecs[i].aw,
              $sformatf("vec%0d", i));
      if (vecs[i].err == 5) begin
        aw_cycles = (cyc - 1) - first_aw_cyc;
        chk("aw_timeout_window", (aw_cycles >= (1 << TW) - 1) && (aw_cycles <= (1 << TW) + 1), 1);
      end
    end
    pct_rdy = 100; pct_v = 100; bresp_cfg = 2'b00;

    // Reset in the middle of an 8-beat burst, then restart.
    router = 4'b0001; address = '0; length = '0;
    address[31:0] = 32'h2000; length[31:0] = 8;
    aw_addr_log.delete(); aw_len_log.delete();
    cur_ch = 0; beats_job = 0; first_aw_cyc = -1; start_cyc = cyc;
    cycle(1'b1);
    for (int n = 0; n < 50 && beats_job < 3; n++) cycle(1'b0);
    chk("midburst_reached_beat3", beats_job, 3);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_busy_done_error", {busy, done, error}, 0);
    chk("midrst_etype", etype, 0);
    chk("midrst_aw_w_b", {awvalid, wvalid, wlast, bready}, 0);
    chk("midrst_data_next", data_next, 0);
    chk("midrst_awaddr_wdata", {awaddr, wdata}, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    prev_awvalid = 1'b0; last_aw = 1'b0;
    cycle(1'b0);
    chk("after_rst_idle", {s_busy, s_done, s_error}, 0);
    run_job(4'b0001, 32'h2000, 8, 0, 0, "restart");

    // Random jobs with noisy router/address/length and ignored starts while busy.
    noise = 1'b1;
    for (int j = 0; j < 12; j++) begin
      int unsigned b, l;
      int          c;
      c = int'($urandom_range(0, CH - 1));
      if ($urandom % 2 == 0) b = 32'h5000 - BY * $urandom_range(0, 24);
      else                   b = ($urandom % 32'h10000) & ~(BY - 1);
      l = $urandom_range(1, 70);
      pct_rdy = $urandom_range(30, 100);
      pct_v   = $urandom_range(30, 100);
      run_job(CH'(1 << c), b, l, 0, 0, $sformatf("rnd%0d", j));
    end
    noise = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
